// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the MIPS fetch stage.
// Selects sequential increment, taken branch or jump each cycle, holds the
// PC on stalls, inserts a one-cycle fetch bubble after every redirect and
// parks in HALT until reset.
// Optional feature: define PC_SEQ_WRAP_TRAP_EN to trap a sequential wrap
// from the last address to 0 (sticky wrap_err, FSM goes to HALT).
module pc_sequencer #(
  parameter int PC_WIDTH  = 6,
  parameter int RESET_VEC = 0,
  parameter int BOOT_HOLD = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                br_taken,
  input  logic [PC_WIDTH-1:0] br_offset,
  input  logic                jmp,
  input  logic [PC_WIDTH-1:0] jmp_target,
  input  logic                halt,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus1,
  output logic                fetch_valid,
  output logic                flush,
  output logic [1:0]          state,
  output logic [7:0]          redirect_cnt,
  output logic                wrap_err
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Boot hold is clamped to the supported 1..15 range of the 4-bit counter.
  localparam int BOOT_HOLD_C =
    (BOOT_HOLD < 1) ? 1 : ((BOOT_HOLD > 15) ? 15 : BOOT_HOLD);
  localparam logic [3:0]          BOOT_LAST = 4'(BOOT_HOLD_C - 1);
  localparam logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(RESET_VEC);
  localparam logic [PC_WIDTH-1:0] PC_ONE    = PC_WIDTH'(1);
`ifdef PC_SEQ_WRAP_TRAP_EN
  localparam logic [PC_WIDTH-1:0] PC_MAX    = {PC_WIDTH{1'b1}};
`endif

  // Saturating increment for the redirect counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  state_t              state_r, state_s;
  logic [PC_WIDTH-1:0] pc_r, pc_s;
  logic                fv_r, fv_s;
  logic                flush_r, flush_s;
  logic [3:0]          boot_cnt_r, boot_cnt_s;
  logic [7:0]          cnt_r, cnt_s;
`ifdef PC_SEQ_WRAP_TRAP_EN
  logic                wrap_err_r, wrap_err_s;
`endif

  logic                redirect_s;
  logic [PC_WIDTH-1:0] target_s;

  // Redirect request and its target address; jump wins over branch.
  always_comb begin
    redirect_s = jmp | br_taken;
    if (jmp) begin
      target_s = jmp_target;
    end else begin
      // Branch offset is relative to pc+1, two's complement, wraps modulo.
      target_s = pc_plus1 + br_offset;
    end
  end

  // Next-state and next-output decode; every register holds by default.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    fv_s       = fv_r;
    flush_s    = flush_r;
    boot_cnt_s = boot_cnt_r;
    cnt_s      = cnt_r;
`ifdef PC_SEQ_WRAP_TRAP_EN
    wrap_err_s = wrap_err_r;
`endif
    case (state_r)
      ST_BOOT: begin
        // Redirects and stalls are ignored while the core comes out of reset.
        pc_s    = RESET_PC;
        flush_s = 1'b0;
        if (boot_cnt_r >= BOOT_LAST) begin
          state_s    = ST_RUN;
          fv_s       = 1'b1;
          boot_cnt_s = boot_cnt_r;
        end else begin
          fv_s       = 1'b0;
          boot_cnt_s = boot_cnt_r + 4'd1;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_s = ST_HALT;
          fv_s    = 1'b0;
          flush_s = 1'b0;
        end else if (redirect_s) begin
          state_s = ST_FLUSH;
          pc_s    = target_s;
          fv_s    = 1'b0;
          flush_s = 1'b1;
          cnt_s   = sat_inc8(cnt_r);
        end else if (stall) begin
          // Same address re-presented, still a valid fetch.
          fv_s    = 1'b1;
          flush_s = 1'b0;
        end else begin
          flush_s = 1'b0;
`ifdef PC_SEQ_WRAP_TRAP_EN
          if (pc_r == PC_MAX) begin
            pc_s       = {PC_WIDTH{1'b0}};
            wrap_err_s = 1'b1;
            state_s    = ST_HALT;
            fv_s       = 1'b0;
          end else begin
            pc_s = pc_plus1;
            fv_s = 1'b1;
          end
`else
          pc_s = pc_plus1;
          fv_s = 1'b1;
`endif
        end
      end
      ST_FLUSH: begin
        // Stall is ignored here: the bubble always lasts exactly one cycle
        // unless another redirect re-arms it.
        if (halt) begin
          state_s = ST_HALT;
          fv_s    = 1'b0;
          flush_s = 1'b0;
        end else if (redirect_s) begin
          state_s = ST_FLUSH;
          pc_s    = target_s;
          fv_s    = 1'b0;
          flush_s = 1'b1;
          cnt_s   = sat_inc8(cnt_r);
        end else begin
          state_s = ST_RUN;
          fv_s    = 1'b1;
          flush_s = 1'b0;
        end
      end
      ST_HALT: begin
        // Only reset leaves HALT.
        fv_s    = 1'b0;
        flush_s = 1'b0;
      end
      default: begin
        state_s    = ST_BOOT;
        pc_s       = RESET_PC;
        fv_s       = 1'b0;
        flush_s    = 1'b0;
        boot_cnt_s = 4'd0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_BOOT;
      pc_r       <= RESET_PC;
      fv_r       <= 1'b0;
      flush_r    <= 1'b0;
      boot_cnt_r <= 4'd0;
      cnt_r      <= 8'd0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      fv_r       <= fv_s;
      flush_r    <= flush_s;
      boot_cnt_r <= boot_cnt_s;
      cnt_r      <= cnt_s;
    end
  end

`ifdef PC_SEQ_WRAP_TRAP_EN
  // Sticky wrap error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_err_r <= 1'b0;
    end else begin
      wrap_err_r <= wrap_err_s;
    end
  end

  assign wrap_err = wrap_err_r;
`else
  assign wrap_err = 1'b0;
`endif

  assign pc           = pc_r;
  assign pc_plus1     = pc_r + PC_ONE;
  assign fetch_valid  = fv_r;
  assign flush        = flush_r;
  assign state        = state_r;
  assign redirect_cnt = cnt_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized traffic
// checked against a behavioural next-PC model.
module tb_pc_sequencer;

  localparam int W  = 6;
  localparam int BH = 2;
`ifdef PC_SEQ_WRAP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic         clk, rst, stall, br_taken, jmp, halt;
  logic [W-1:0] br_offset, jmp_target;
  logic [W-1:0] pc, pc_plus1;
  logic         fetch_valid, flush, wrap_err;
  logic [1:0]   state;
  logic [7:0]   redirect_cnt;

  int total = 0;
  int bad   = 0;

  // Behavioural model
  int m_boot_left, m_pc, m_cnt;
  bit m_fv, m_flush, m_halted, m_flushing, m_werr;

  pc_sequencer #(.PC_WIDTH(W), .RESET_VEC(0), .BOOT_HOLD(BH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken),
    .br_offset(br_offset), .jmp(jmp), .jmp_target(jmp_target), .halt(halt),
    .pc(pc), .pc_plus1(pc_plus1), .fetch_valid(fetch_valid), .flush(flush),
    .state(state), .redirect_cnt(redirect_cnt), .wrap_err(wrap_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_boot_left = BH; m_pc = 0; m_cnt = 0;
    m_fv = 0; m_flush = 0; m_halted = 0; m_flushing = 0; m_werr = 0;
  endtask

  function automatic logic [1:0] exp_state();
    if (m_boot_left != 0) return 2'd0;
    else if (m_halted)    return 2'd3;
    else if (m_flushing)  return 2'd2;
    else                  return 2'd1;
  endfunction

  // One clock edge of the model, from the rules of the next-PC controller.
  task automatic model_edge();
    int off;
    off = int'(br_offset);
    if (off >= 32) off = off - 64;
    if (m_boot_left != 0) begin
      m_boot_left--; m_pc = 0; m_flush = 0; m_fv = (m_boot_left == 0);
    end else if (m_halted) begin
      m_fv = 0; m_flush = 0;
    end else if (halt) begin
      m_halted = 1; m_fv = 0; m_flush = 0;
    end else if (jmp || br_taken) begin
      m_pc = jmp ? int'(jmp_target) : ((m_pc + 1 + off) & 63);
      m_flushing = 1; m_flush = 1; m_fv = 0;
      if (m_cnt < 255) m_cnt++;
    end else if (m_flushing) begin
      m_flushing = 0; m_flush = 0; m_fv = 1;
    end else if (stall) begin
      m_fv = 1; m_flush = 0;
    end else begin
      m_flush = 0;
      if (TRAP && m_pc == 63) begin
        m_pc = 0; m_werr = 1; m_halted = 1; m_fv = 0;
      end else begin
        m_pc = (m_pc + 1) & 63; m_fv = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    stall = 0; br_taken = 0; jmp = 0; halt = 0;
    br_offset = '0; jmp_target = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic jump_to(input int a);
    jmp = 1; jmp_target = W'(a);
    step();
    jmp = 0;
    step();
  endtask

  task automatic test_reset();
    total++; if (pc !== 6'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%0b exp=0", fetch_valid); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%0b exp=0", flush); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++; if (redirect_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", redirect_cnt); end
    total++; if (wrap_err !== 1'b0) begin bad++; $display("FAIL reset_werr got=%0b exp=0", wrap_err); end
  endtask

  task automatic test_boot();
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL boot_fv0 got=%0b exp=0", fetch_valid); end
    step();
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL boot_fv1 got=%0b exp=0", fetch_valid); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL boot_state1 got=%0d exp=0", state); end
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (pc !== W'(i)) begin bad++; $display("FAIL boot_seq_pc got=%0d exp=%0d", pc, i); end
      total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL boot_seq_fv got=%0b exp=1", fetch_valid); end
      total++; if (state !== 2'd1) begin bad++; $display("FAIL boot_seq_state got=%0d exp=1", state); end
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 70 && m_pc != 5; i++) step();
    br_taken = 1; br_offset = 6'd3;
    step();
    br_taken = 0;
    total++; if (pc !== 6'd9) begin bad++; $display("FAIL br_pc got=%0d exp=9", pc); end
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL br_flush got=%0b exp=1", flush); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL br_fv got=%0b exp=0", fetch_valid); end
    total++; if (redirect_cnt !== 8'd1) begin bad++; $display("FAIL br_cnt got=%0d exp=1", redirect_cnt); end
    step();
    total++; if (pc !== 6'd9 || fetch_valid !== 1'b1 || flush !== 1'b0) begin
      bad++; $display("FAIL br_present got pc=%0d fv=%0b fl=%0b exp pc=9 fv=1 fl=0", pc, fetch_valid, flush);
    end
    step();
    total++; if (pc !== 6'd10) begin bad++; $display("FAIL br_next got=%0d exp=10", pc); end
  endtask

  task automatic test_neg_branch_priority();
    jump_to(3);
    br_taken = 1; br_offset = 6'b111011;
    step();
    br_taken = 0;
    total++; if (pc !== 6'd63) begin bad++; $display("FAIL negbr_pc got=%0d exp=63", pc); end
    step();
    br_taken = 1; br_offset = 6'd4; jmp = 1; jmp_target = 6'd20;
    step();
    br_taken = 0; jmp = 0;
    total++; if (pc !== 6'd20) begin bad++; $display("FAIL jmp_over_br got=%0d exp=20", pc); end
    step();
  endtask

  task automatic test_stall();
    int c0;
    jump_to(7);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (pc !== 6'd7 || fetch_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold got pc=%0d fv=%0b exp pc=7 fv=1", pc, fetch_valid);
      end
    end
    c0 = m_cnt;
    jmp = 1; jmp_target = 6'd12;
    step();
    stall = 0;
    total++; if (pc !== 6'd12 || state !== 2'd2) begin
      bad++; $display("FAIL stall_jmp got pc=%0d st=%0d exp pc=12 st=2", pc, state);
    end
    jmp_target = 6'd30;
    step();
    jmp = 0;
    total++; if (pc !== 6'd30 || flush !== 1'b1 || state !== 2'd2) begin
      bad++; $display("FAIL flush_rejmp got pc=%0d fl=%0b st=%0d exp pc=30 fl=1 st=2", pc, flush, state);
    end
    total++; if (int'(redirect_cnt) !== c0 + 2) begin
      bad++; $display("FAIL flush_cnt got=%0d exp=%0d", redirect_cnt, c0 + 2);
    end
    step();
    total++; if (pc !== 6'd30 || fetch_valid !== 1'b1 || state !== 2'd1) begin
      bad++; $display("FAIL flush_exit got pc=%0d fv=%0b st=%0d exp pc=30 fv=1 st=1", pc, fetch_valid, state);
    end
  endtask

  task automatic test_wrap();
    jump_to(63);
    step();
    total++; if (pc !== 6'd0) begin bad++; $display("FAIL wrap_pc got=%0d exp=0", pc); end
    total++; if (wrap_err !== TRAP) begin bad++; $display("FAIL wrap_err got=%0b exp=%0b", wrap_err, TRAP); end
    total++; if (state !== (TRAP ? 2'd3 : 2'd1)) begin bad++; $display("FAIL wrap_state got=%0d exp=%0d", state, TRAP ? 3 : 1); end
    total++; if (fetch_valid !== !TRAP) begin bad++; $display("FAIL wrap_fv got=%0b exp=%0b", fetch_valid, !TRAP); end
  endtask

  task automatic test_halt();
    apply_reset();
    for (int i = 0; i < BH; i++) step();
    jump_to(9);
    halt = 1; jmp = 1; jmp_target = 6'd40;
    step();
    halt = 0;
    for (int i = 0; i < 3; i++) begin
      total++; if (state !== 2'd3 || pc !== 6'd9 || fetch_valid !== 1'b0 || flush !== 1'b0) begin
        bad++; $display("FAIL halt_hold got st=%0d pc=%0d fv=%0b fl=%0b exp st=3 pc=9 fv=0 fl=0", state, pc, fetch_valid, flush);
      end
      step();
    end
    jmp = 0;
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    total++; if (pc !== 6'd0 || state !== 2'd0 || redirect_cnt !== 8'd0 || fetch_valid !== 1'b0) begin
      bad++; $display("FAIL async_rst got pc=%0d st=%0d cnt=%0d fv=%0b exp 0/0/0/0", pc, state, redirect_cnt, fetch_valid);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < BH; i++) step();
    jmp = 1;
    for (int i = 0; i < 260; i++) begin
      jmp_target = W'($urandom_range(0, 63));
      step();
    end
    jmp = 0;
    total++; if (redirect_cnt !== 8'd255 || state !== 2'd2) begin
      bad++; $display("FAIL sat_cnt got cnt=%0d st=%0d exp cnt=255 st=2", redirect_cnt, state);
    end
    step();
    total++; if (state !== 2'd1) begin bad++; $display("FAIL sat_exit got=%0d exp=1", state); end
  endtask

  task automatic test_random();
    logic [W+W+1+1+2+8+1-1:0] got, exp;
    for (int i = 0; i < 600; i++) begin
      halt       = ($urandom_range(0, 79) == 0);
      jmp        = ($urandom_range(0, 5) == 0);
      br_taken   = ($urandom_range(0, 4) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      jmp_target = W'($urandom_range(0, 63));
      br_offset  = W'($urandom_range(0, 63));
      step();
      total++; if (pc !== W'(m_pc)) begin bad++; $display("FAIL rand_pc cyc=%0d got=%0d exp=%0d", i, pc, m_pc); end
      got = {pc_plus1, fetch_valid, flush, state, redirect_cnt, wrap_err};
      exp = {W'(m_pc + 1), m_fv, m_flush, exp_state(), 8'(m_cnt), m_werr};
      total++; if (got !== exp) begin
        bad++; $display("FAIL rand_out cyc=%0d got=%h exp=%h", i, got, exp);
      end
      if (m_halted && $urandom_range(0, 3) == 0) begin
        idle();
        apply_reset();
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    model_reset();
    #3;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_boot();
    test_branch();
    test_neg_branch_priority();
    test_stall();
    test_wrap();
    test_halt();
    test_async_reset();
    test_saturate();
    apply_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller that drives the program counter register of the MIPS core. Each cycle it selects the next instruction address from sequential increment, a taken branch, or a jump. It also holds the PC on pipeline stalls and inserts a one-cycle fetch bubble after every redirect. It sits between the decode/hazard logic and the instruction memory address port.

## Interface
- PC_WIDTH, 6, word-address width of the PC; matches the instruction memory depth.
- RESET_VEC, 0, PC value loaded on reset.
- BOOT_HOLD, 2, cycles after reset release before the first valid fetch; range 1..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  1  hazard hold; PC keeps its value.
- br_taken  in  1  conditional branch resolved taken this cycle.
- br_offset  in  PC_WIDTH  signed word offset, relative to pc+1.
- jmp  in  1  unconditional jump this cycle.
- jmp_target  in  PC_WIDTH  absolute word address for the jump.
- halt  in  1  stop fetching until reset.
- pc  out  PC_WIDTH  current fetch address; registered.
- pc_plus1  out  PC_WIDTH  pc+1 mod 2^PC_WIDTH; combinational from pc.
- fetch_valid  out  1  pc is a real fetch this cycle; registered.
- flush  out  1  kill the instruction in fetch/decode; registered, one-cycle pulse.
- state  out  2  FSM state: BOOT=0, RUN=1, FLUSH=2, HALT=3.
- redirect_cnt  out  8  count of accepted redirects, saturating at 255.
- wrap_err  out  1  sticky sequential-wrap error; see Configuration.

## Operation
- FSM states: BOOT, RUN, FLUSH, HALT.
- BOOT:
  - pc=RESET_VEC, fetch_valid=0.
  - Internal counter counts BOOT_HOLD edges, then the FSM moves to RUN with fetch_valid<=1.
  - jmp, br_taken and stall are ignored.
- RUN, evaluated in priority order:
  - halt: go to HALT.
  - jmp: pc<=jmp_target.
  - br_taken: pc<=pc+1+br_offset.
  - stall: pc holds.
  - otherwise: pc<=pc+1.
- Any accepted jmp or br_taken is a redirect. A redirect sets state<=FLUSH, flush<=1, fetch_valid<=0, and redirect_cnt+=1, saturating at 255.
- FLUSH:
  - pc holds the target.
  - Next edge: state<=RUN, flush<=0, fetch_valid<=1.
  - A new jmp or br_taken arriving in FLUSH is accepted: pc is reloaded, the FSM stays in FLUSH, flush stays 1, and the count increments.
  - stall in FLUSH is ignored.
- HALT:
  - pc holds, fetch_valid=0, flush=0.
  - Exit only by reset.
- Arithmetic: all PC math is modulo 2^PC_WIDTH; br_offset is two's complement.
- Simultaneous events: halt beats redirect, redirect beats stall, jmp beats br_taken.
- Stall in RUN: fetch_valid stays 1, and the same address is re-presented.

## Timing
- Reset (rst low, asynchronous): pc=RESET_VEC, fetch_valid=0, flush=0, state=BOOT, boot counter=0, redirect_cnt=0, wrap_err=0.
- Reset asserted mid-operation overrides everything immediately, without waiting for an edge.
- Redirect latency: target appears on pc one edge after the redirect input is sampled.
  - The target is then held one cycle with fetch_valid=0 and flush=1.
  - It is then presented with fetch_valid=1 for one cycle before incrementing.
- Sequential fetch: one address per cycle, zero bubbles.
- Outputs other than pc_plus1 change only on clk rising edge or on rst assertion.

## Configuration
- PC_SEQ_WRAP_TRAP_EN defined:
  - Applies to a sequential increment from pc=2^PC_WIDTH-1 in RUN.
  - On that increment pc<=0, wrap_err<=1 (sticky until reset), and the next state is HALT.
  - Redirect targets that wrap do not trap.
- Not defined: sequential wrap to 0 is silent and wrap_err is tied to 0.

## Test plan
- Reset release, defaults: fetch_valid=0 for 2 cycles, then pc=0,1,2,3 with fetch_valid=1 and state=RUN.
- Taken branch at pc=5, br_offset=3:
  - Next cycle: pc=9, flush=1, fetch_valid=0.
  - Then pc=9 with fetch_valid=1, then pc=10.
  - redirect_cnt=1.
- Negative branch at pc=3, br_offset=6'b111011 (-5): pc=63. Same cycle, jmp=1 with jmp_target=20 alongside br_taken: pc=20.
- Redirect arbitration:
  - stall=1 for 3 cycles at pc=7: pc stays 7 and fetch_valid stays 1.
  - stall=1 together with jmp to 12: pc=12, stall ignored.
  - Second jmp to 30 during FLUSH: pc=30, flush held, redirect_cnt increments twice.
- Sequential wrap from pc=63:
  - Without the macro: pc=0, wrap_err=0.
  - With PC_SEQ_WRAP_TRAP_EN: pc=0, wrap_err=1, state=HALT, fetch_valid=0.
- halt and rst:
  - halt=1 at pc=9: state=HALT and pc frozen at 9 despite jmp.
  - rst low mid-cycle: pc=0 and state=BOOT immediately; redirect_cnt=0.
